// File: rtl/move_stack.sv
// move_stack: LIFO of ant moves for the ant-farm datapath.
// The controller pushes each executed move while exploring and pops them to
// backtrack. Storage is a circular array so that, with DROP_OLDEST=1, a push
// on a full stack silently overwrites the oldest move instead of stalling.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - asynchronous active-high reset
//   clear      - synchronous flush (push/pop ignored that cycle, no flags)
//   push       - push request, push_move is the move to store
//   pop        - pop request
//   pop_valid  - one-cycle pulse, pop_move holds the popped move
//   pop_move   - registered popped move (optionally direction-reversed)
//   top_move   - raw top entry, 0 when empty
//   empty/full - status derived from count
//   count      - number of stored entries
//   overflow   - pulse: push on a full stack (rejected or oldest dropped)
//   underflow  - pulse: pop on an empty stack with no push to pass through
module move_stack #(
    parameter int W              = 3,
    parameter int DEPTH          = 32,
    parameter int CW             = 6,
    parameter int DROP_OLDEST    = 0,
    parameter int REVERSE_ON_POP = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic [W-1:0]  push_move,
    input  logic          pop,
    output logic          pop_valid,
    output logic [W-1:0]  pop_move,
    output logic [W-1:0]  top_move,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Inverting the MSB of an 8-direction code yields the opposite direction.
    localparam logic [W-1:0] REV_MASK =
        (REVERSE_ON_POP != 0) ? (W'(1) << (W - 1)) : '0;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] ptr;
    logic [AW-1:0] top_idx;
    logic [W-1:0]  top_raw;
    logic [CW-1:0] cnt;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;

    assign top_idx  = ptr - AW'(1);
    assign top_raw  = mem[top_idx];
    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign count    = cnt;
    assign top_move = empty ? '0 : top_raw;

    // Push+pop on a non-empty stack replaces the top in place; on an empty
    // stack it is a pure pass-through and nothing is written.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ptr;
        if (!clear && push) begin
            if (pop) begin
                mem_we    = !empty;
                mem_waddr = top_idx;
            end else begin
                mem_we    = !full || (DROP_OLDEST != 0);
                mem_waddr = ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= push_move;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            cnt       <= '0;
            pop_valid <= 1'b0;
            pop_move  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            if (clear) begin
                ptr      <= '0;
                cnt      <= '0;
                pop_move <= '0;
            end else if (push && pop) begin
                pop_valid <= 1'b1;
                pop_move  <= (empty ? push_move : top_raw) ^ REV_MASK;
            end else if (push) begin
                if (!full) begin
                    ptr <= ptr + AW'(1);
                    cnt <= cnt + CW'(1);
                end else begin
                    overflow <= 1'b1;
                    // Full circular buffer: advancing ptr overwrites the oldest.
                    if (DROP_OLDEST != 0)
                        ptr <= ptr + AW'(1);
                end
            end else if (pop) begin
                if (!empty) begin
                    pop_valid <= 1'b1;
                    pop_move  <= top_raw ^ REV_MASK;
                    ptr       <= top_idx;
                    cnt       <= cnt - CW'(1);
                end else begin
                    underflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_move_stack.sv
// Directed bench for move_stack: four instances share the stimulus, each
// test checks the instance whose parameters it exercises.
module tb_move_stack;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       push = 1'b0;
    logic [2:0] push_move = '0;
    logic       pop = 1'b0;

    // a: defaults, r: DEPTH=4 reject, d: DEPTH=4 drop oldest, v: reverse on pop
    logic       a_pv, r_pv, d_pv, v_pv;
    logic [2:0] a_pm, r_pm, d_pm, v_pm;
    logic [2:0] a_top, r_top, d_top, v_top;
    logic       a_em, r_em, d_em, v_em;
    logic       a_fu, r_fu, d_fu, v_fu;
    logic [5:0] a_cnt, v_cnt;
    logic [2:0] r_cnt, d_cnt;
    logic       a_ov, r_ov, d_ov, v_ov;
    logic       a_un, r_un, d_un, v_un;

    int n_tests = 0;
    int n_fail  = 0;
    int ov_seen;

    always #5 clk = ~clk;

    move_stack u_a (
        .clk(clk), .rst(rst), .clear(clear), .push(push), .push_move(push_move),
        .pop(pop), .pop_valid(a_pv), .pop_move(a_pm), .top_move(a_top),
        .empty(a_em), .full(a_fu), .count(a_cnt), .overflow(a_ov), .underflow(a_un)
    );

    move_stack #(.W(3), .DEPTH(4), .CW(3), .DROP_OLDEST(0), .REVERSE_ON_POP(0)) u_r (
        .clk(clk), .rst(rst), .clear(clear), .push(push), .push_move(push_move),
        .pop(pop), .pop_valid(r_pv), .pop_move(r_pm), .top_move(r_top),
        .empty(r_em), .full(r_fu), .count(r_cnt), .overflow(r_ov), .underflow(r_un)
    );

    move_stack #(.W(3), .DEPTH(4), .CW(3), .DROP_OLDEST(1), .REVERSE_ON_POP(0)) u_d (
        .clk(clk), .rst(rst), .clear(clear), .push(push), .push_move(push_move),
        .pop(pop), .pop_valid(d_pv), .pop_move(d_pm), .top_move(d_top),
        .empty(d_em), .full(d_fu), .count(d_cnt), .overflow(d_ov), .underflow(d_un)
    );

    move_stack #(.W(3), .DEPTH(32), .CW(6), .DROP_OLDEST(0), .REVERSE_ON_POP(1)) u_v (
        .clk(clk), .rst(rst), .clear(clear), .push(push), .push_move(push_move),
        .pop(pop), .pop_valid(v_pv), .pop_move(v_pm), .top_move(v_top),
        .empty(v_em), .full(v_fu), .count(v_cnt), .overflow(v_ov), .underflow(v_un)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus; returns #1 after the sampling edge.
    task automatic cyc(input logic p, input logic [2:0] pm, input logic q);
        push      = p;
        push_move = pm;
        pop       = q;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // 1: reset, push/pop, underflow
        rst = 1'b1;
        #2;
        check("rst_empty", a_em, 1);
        check("rst_count", a_cnt, 0);
        check("rst_top", a_top, 0);
        check("rst_pv", a_pv, 0);
        check("rst_pm", a_pm, 0);
        check("rst_full", a_fu, 0);
        @(posedge clk); #1; rst = 1'b0;
        cyc(1, 3'd1, 0); cyc(1, 3'd2, 0); cyc(1, 3'd3, 0);
        check("t1_count", a_cnt, 3);
        check("t1_top", a_top, 3);
        check("t1_empty", a_em, 0);
        cyc(0, 0, 1); check("t1_pop1", a_pm, 3); check("t1_pv1", a_pv, 1);
        cyc(0, 0, 1); check("t1_pop2", a_pm, 2); check("t1_pv2", a_pv, 1);
        cyc(0, 0, 1); check("t1_pop3", a_pm, 1); check("t1_pv3", a_pv, 1);
        check("t1_empty_after", a_em, 1);
        check("t1_top_empty", a_top, 0);
        cyc(0, 0, 1);
        check("t1_underflow", a_un, 1);
        check("t1_pv_under", a_pv, 0);
        check("t1_pm_hold", a_pm, 1);
        cyc(0, 0, 0);
        check("t1_underflow_pulse", a_un, 0);

        // 2: reject on full, plus push+pop while full
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 3'(i), 0);
        check("t2_full", r_fu, 1);
        check("t2_count", r_cnt, 4);
        cyc(1, 3'd5, 0);
        check("t2_overflow", r_ov, 1);
        check("t2_top", r_top, 3);
        check("t2_count_hold", r_cnt, 4);
        cyc(0, 0, 0);
        check("t2_ov_pulse", r_ov, 0);
        cyc(1, 3'd7, 1);
        check("t2_pp_pm", r_pm, 3);
        check("t2_pp_ov", r_ov, 0);
        check("t2_pp_top", r_top, 7);
        check("t2_pp_count", r_cnt, 4);
        cyc(0, 0, 1); check("t2_pop1", r_pm, 7);
        cyc(0, 0, 1); check("t2_pop2", r_pm, 2);
        cyc(0, 0, 1); check("t2_pop3", r_pm, 1);
        cyc(0, 0, 1); check("t2_pop4", r_pm, 0);
        check("t2_empty", r_em, 1);

        // 3: drop oldest, pointer wraps
        do_reset();
        ov_seen = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1, 3'(i), 0);
            if (d_ov) ov_seen++;
        end
        check("t3_count", d_cnt, 4);
        check("t3_ov_pulses", ov_seen, 2);
        check("t3_top", d_top, 5);
        cyc(0, 0, 1); check("t3_pop1", d_pm, 5);
        cyc(0, 0, 1); check("t3_pop2", d_pm, 4);
        cyc(0, 0, 1); check("t3_pop3", d_pm, 3);
        cyc(0, 0, 1); check("t3_pop4", d_pm, 2);
        cyc(0, 0, 1);
        check("t3_underflow", d_un, 1);
        check("t3_pv", d_pv, 0);

        // 4: reverse on pop
        do_reset();
        cyc(1, 3'd1, 0); cyc(1, 3'd6, 0);
        check("t4_top", v_top, 6);
        cyc(0, 0, 1); check("t4_pop1", v_pm, 2);
        cyc(0, 0, 1); check("t4_pop2", v_pm, 5);

        // 5: simultaneous push+pop
        do_reset();
        cyc(1, 3'd1, 0); cyc(1, 3'd2, 0);
        cyc(1, 3'd7, 1);
        check("t5_pm", a_pm, 2);
        check("t5_pv", a_pv, 1);
        check("t5_count", a_cnt, 2);
        check("t5_top", a_top, 7);
        check("t5_rev_pm", v_pm, 6);
        cyc(0, 0, 1); check("t5_pop7", a_pm, 7);
        cyc(0, 0, 1); check("t5_pop1", a_pm, 1);
        cyc(1, 3'd4, 1);
        check("t5_pass_pm", a_pm, 4);
        check("t5_pass_pv", a_pv, 1);
        check("t5_pass_empty", a_em, 1);
        check("t5_pass_un", a_un, 0);
        check("t5_pass_count", a_cnt, 0);
        check("t5_pass_rev", v_pm, 0);

        // 6: clear with push, then asynchronous reset mid-cycle
        do_reset();
        cyc(1, 3'd1, 0); cyc(1, 3'd2, 0); cyc(1, 3'd3, 0);
        check("t6_count3", a_cnt, 3);
        clear = 1'b1;
        cyc(1, 3'd6, 0);
        clear = 1'b0;
        check("t6_clr_count", a_cnt, 0);
        check("t6_clr_empty", a_em, 1);
        check("t6_clr_ov", a_ov, 0);
        check("t6_clr_pv", a_pv, 0);
        check("t6_clr_top", a_top, 0);
        cyc(1, 3'd5, 0); cyc(1, 3'd6, 0);
        cyc(0, 0, 1);
        check("t6_pre_pm", a_pm, 6);
        #2;
        rst = 1'b1;
        #1;
        check("t6_arst_count", a_cnt, 0);
        check("t6_arst_empty", a_em, 1);
        check("t6_arst_pv", a_pv, 0);
        check("t6_arst_pm", a_pm, 0);
        check("t6_arst_top", a_top, 0);
        @(posedge clk); #1; rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
